// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data-side responder: funct3 access sizes,
// MMIO register offsets and fault-status bit positions.
package data_mem_responder_pkg;

  // Load/store funct3 encodings (Instr[14:12])
  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  // MMIO byte offsets from the window base
  localparam logic [15:0] MMIO_LED    = 16'h0000;
  localparam logic [15:0] MMIO_CYCLES = 16'h0004;
  localparam logic [15:0] MMIO_STORES = 16'h0008;
  localparam logic [15:0] MMIO_FSTAT  = 16'h000C;
  localparam logic [15:0] MMIO_FADDR  = 16'h0010;

  // Fault status bit indices
  localparam int FS_MISALIGN = 0;  // misaligned store
  localparam int FS_ILLEGAL  = 1;  // bad funct3, or non-word MMIO store
  localparam int FS_RO       = 2;  // store to read-only / unmapped MMIO

  typedef logic [2:0] fstat_t;

endpackage

// File: rtl/data_mem_responder_lsu_align.sv
// Lane alignment for loads and stores: picks and extends the addressed
// byte/half on the read side, and builds byte enables plus replicated
// write data on the store side. Purely combinational.
module data_mem_responder_lsu_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rword,
  output logic [31:0] rdata,
  output logic [31:0] wdata_rep,
  output logic [3:0]  byte_en,
  output logic        st_misalign,
  output logic        st_illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Load side: select lane, extend; misaligned or unknown sizes read as 0
  always_comb begin
    lane_b = rword[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];
    rdata  = 32'h0;
    case (funct3)
      F3_B:  rdata = {{24{lane_b[7]}}, lane_b};
      F3_BU: rdata = {24'h0, lane_b};
      F3_H:  rdata = addr_lo[0] ? 32'h0 : {{16{lane_h[15]}}, lane_h};
      F3_HU: rdata = addr_lo[0] ? 32'h0 : {16'h0, lane_h};
      F3_W:  rdata = (addr_lo != 2'b00) ? 32'h0 : rword;
      default: rdata = 32'h0;
    endcase
  end

  // Store side: byte enables and lane-replicated data; flags suppress writes
  always_comb begin
    wdata_rep   = wdata_in;
    byte_en     = 4'b0000;
    st_misalign = 1'b0;
    st_illegal  = 1'b0;
    case (funct3)
      F3_B: begin
        wdata_rep = {4{wdata_in[7:0]}};
        byte_en   = 4'b0001 << addr_lo;
      end
      F3_H: begin
        wdata_rep   = {2{wdata_in[15:0]}};
        st_misalign = addr_lo[0];
        byte_en     = addr_lo[0] ? 4'b0000 : (addr_lo[1] ? 4'b1100 : 4'b0011);
      end
      F3_W: begin
        st_misalign = (addr_lo != 2'b00);
        byte_en     = st_misalign ? 4'b0000 : 4'b1111;
      end
      default: st_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-side responder for the single-cycle CPU. Combinational reads from a
// word-organised RAM or a small MMIO register window; stores commit on the
// rising clock edge. Illegal stores are dropped and logged in sticky status.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  LedOut,
  output logic        Fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [7:0]  led_q,    led_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] stores_q, stores_d;
  fstat_t      fstat_q,  fstat_d;
  logic [31:0] faddr_q,  faddr_d;

  logic          is_mmio;
  logic [15:0]   mmio_off;
  logic [AW-1:0] word_idx;
  logic [31:0]   mmio_rd;
  logic [31:0]   rword;
  logic [31:0]   wdata_rep;
  logic [3:0]    byte_en;
  logic          st_misalign, st_illegal;
  logic          ram_we, led_we;
  fstat_t        fault_set, fstat_clr;

  assign is_mmio  = (Addr[31:16] == MMIO_BASE[31:16]);
  assign mmio_off = Addr[15:0] - MMIO_BASE[15:0];
  assign word_idx = Addr[AW+1:2];

  // MMIO read mux; unmapped offsets read 0
  always_comb begin
    mmio_rd = 32'h0;
    case (mmio_off)
      MMIO_LED:    mmio_rd = {24'h0, led_q};
      MMIO_CYCLES: mmio_rd = cycles_q;
      MMIO_STORES: mmio_rd = stores_q;
      MMIO_FSTAT:  mmio_rd = {29'h0, fstat_q};
      MMIO_FADDR:  mmio_rd = faddr_q;
      default:     mmio_rd = 32'h0;
    endcase
  end

  assign rword = is_mmio ? mmio_rd : mem_q[word_idx];

  data_mem_responder_lsu_align u_align (
    .addr_lo     (Addr[1:0]),
    .funct3      (funct3),
    .wdata_in    (WriteData),
    .rword       (rword),
    .rdata       (ReadData),
    .wdata_rep   (wdata_rep),
    .byte_en     (byte_en),
    .st_misalign (st_misalign),
    .st_illegal  (st_illegal)
  );

  // Store decode: route a legal store to RAM/LED/FSTAT, otherwise raise a fault
  always_comb begin
    ram_we    = 1'b0;
    led_we    = 1'b0;
    fault_set = '0;
    fstat_clr = '0;
    if (MemWrite && !Reset) begin
      if (st_illegal) begin
        fault_set[FS_ILLEGAL] = 1'b1;
      end else if (st_misalign) begin
        fault_set[FS_MISALIGN] = 1'b1;
      end else if (is_mmio) begin
        if (funct3 != F3_W) begin
          fault_set[FS_ILLEGAL] = 1'b1;
        end else begin
          case (mmio_off)
            MMIO_LED:   led_we    = 1'b1;
            MMIO_FSTAT: fstat_clr = WriteData[2:0];
            default:    fault_set[FS_RO] = 1'b1;
          endcase
        end
      end else begin
        ram_we = 1'b1;
      end
    end
  end

  // Next-state for MMIO registers; a new fault beats a same-cycle W1C clear
  always_comb begin
    led_d    = led_we ? WriteData[7:0] : led_q;
    cycles_d = cycles_q + 32'd1;
    stores_d = stores_q + {31'h0, (ram_we | led_we)};
    fstat_d  = (fstat_q & ~fstat_clr) | fault_set;
    faddr_d  = ((fault_set != '0) && (fstat_q == '0)) ? Addr : faddr_q;
  end

  // MMIO register state, synchronous reset
  always_ff @(posedge clk) begin
    if (Reset) begin
      led_q    <= 8'h0;
      cycles_q <= 32'h0;
      stores_q <= 32'h0;
      fstat_q  <= '0;
      faddr_q  <= 32'h0;
    end else begin
      led_q    <= led_d;
      cycles_q <= cycles_d;
      stores_q <= stores_d;
      fstat_q  <= fstat_d;
      faddr_q  <= faddr_d;
    end
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  assign LedOut = led_q;
  assign Fault  = |fstat_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder. Stimulus pushes expected values into
// a scoreboard queue; a negedge monitor pops and compares against the DUT.
module tb_data_mem_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;
  localparam int K_RD = 0, K_LED = 1, K_FAULT = 2;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic        clk;
  logic        Reset;
  logic [31:0] Addr;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  LedOut;
  logic        Fault;

  exp_t sb_q[$];
  exp_t mon_e;
  logic [31:0] act;
  int checks = 0;
  int failures = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(MB)) dut (
    .clk(clk), .Reset(Reset), .Addr(Addr), .MemWrite(MemWrite),
    .funct3(funct3), .WriteData(WriteData), .ReadData(ReadData),
    .LedOut(LedOut), .Fault(Fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      case (mon_e.kind)
        K_RD:    act = ReadData;
        K_LED:   act = {24'h0, LedOut};
        default: act = {31'h0, Fault};
      endcase
      checks++;
      if (act !== mon_e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", mon_e.name, act, mon_e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input int kind, input logic [31:0] v, input string nm);
    exp_t e;
    e.kind = kind; e.val = v; e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f,
                    input logic [31:0] ev, input string nm);
    Addr = a; funct3 = f; MemWrite = 1'b0;
    push(K_RD, ev, nm);
    tick();
  endtask

  task automatic chk(input int kind, input logic [31:0] ev, input string nm);
    MemWrite = 1'b0;
    push(kind, ev, nm);
    tick();
  endtask

  task automatic st(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    Addr = a; funct3 = f; WriteData = d; MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Addr = 32'h0; MemWrite = 1'b0; funct3 = 3'b010; WriteData = 32'h0;
    tick(); tick();
    chk(K_LED,   32'h0, "reset_led");
    chk(K_FAULT, 32'h0, "reset_fault");
    Reset = 1'b0;
    // cycle counter: 0 in first cycle after reset, 10 after ten edges
    ld(MB + 32'h4, 3'b010, 32'd0, "cycles_first");
    repeat (9) tick();
    ld(MB + 32'h4, 3'b010, 32'd10, "cycles_ten");
    ld(MB + 32'h8, 3'b010, 32'd0, "stores_init");

    // byte/half sign and zero extension
    st(32'h100, 3'b010, 32'h8000_00FF);
    ld(32'h100, 3'b000, 32'hFFFF_FFFF, "lb_sext");
    ld(32'h100, 3'b100, 32'h0000_00FF, "lbu_zext");
    ld(32'h102, 3'b001, 32'hFFFF_8000, "lh_sext");
    ld(32'h100, 3'b010, 32'h8000_00FF, "lw_word");

    // partial stores merge into existing word
    st(32'h200, 3'b010, 32'h1122_3344);
    st(32'h203, 3'b000, 32'h0000_00AB);
    ld(32'h200, 3'b010, 32'hAB22_3344, "sb_merge");
    st(32'h200, 3'b001, 32'h0000_BEEF);
    ld(32'h200, 3'b010, 32'hAB22_BEEF, "sh_merge");
    ld(32'h202, 3'b101, 32'h0000_AB22, "lhu_upper");
    ld(32'h201, 3'b001, 32'h0, "lh_misaligned");
    ld(32'h200, 3'b011, 32'h0, "load_bad_f3");
    ld(MB + 32'h8, 3'b010, 32'd4, "stores_four");

    // misaligned store: dropped, fault logged with address
    st(32'h300, 3'b010, 32'h0);
    st(32'h301, 3'b010, 32'hDEAD_BEEF);
    chk(K_FAULT, 32'h1, "misalign_fault");
    ld(32'h300, 3'b010, 32'h0, "misalign_nowrite");
    ld(MB + 32'hC, 3'b010, 32'h1, "fstat_misalign");
    ld(MB + 32'h10, 3'b010, 32'h301, "faddr_misalign");
    ld(MB + 32'h8, 3'b010, 32'd5, "stores_unchanged");

    // W1C clear, then LED write
    st(MB + 32'hC, 3'b010, 32'hFF);
    chk(K_FAULT, 32'h0, "w1c_clear");
    st(MB, 3'b010, 32'h5A);
    chk(K_LED, 32'h5A, "led_write");
    ld(MB, 3'b010, 32'h5A, "led_read");
    ld(MB + 32'h8, 3'b010, 32'd6, "stores_led");
    ld(MB + 32'h20, 3'b010, 32'h0, "mmio_unmapped_rd");

    // store to read-only register
    st(MB + 32'h4, 3'b010, 32'h1234);
    ld(MB + 32'hC, 3'b010, 32'h4, "fstat_ro");
    ld(MB + 32'h10, 3'b010, MB + 32'h4, "faddr_ro");
    // sub-word MMIO store to FSTAT faults and does not clear
    st(MB + 32'hC, 3'b000, 32'h7);
    ld(MB + 32'hC, 3'b010, 32'h6, "fstat_sb_mmio");
    ld(MB + 32'h10, 3'b010, MB + 32'h4, "faddr_first_kept");
    st(MB + 32'hC, 3'b010, 32'h7);
    chk(K_FAULT, 32'h0, "w1c_all");

    // illegal store funct3
    st(32'h400, 3'b011, 32'hFFFF_FFFF);
    ld(MB + 32'hC, 3'b010, 32'h2, "fstat_illegal");
    ld(MB + 32'h10, 3'b010, 32'h400, "faddr_illegal");

    // aliasing past DEPTH_WORDS
    st(32'h0, 3'b010, 32'h0000_CAFE);
    ld(32'h1000, 3'b010, 32'h0000_CAFE, "alias_wrap");

    // reset mid-run, with a store attempted during reset
    Reset = 1'b1;
    st(32'h0, 3'b010, 32'h1234_5678);
    Reset = 1'b0;
    ld(MB + 32'h4, 3'b010, 32'd0, "rst_cycles");
    chk(K_LED,   32'h0, "rst_led");
    chk(K_FAULT, 32'h0, "rst_fault");
    ld(MB + 32'h8, 3'b010, 32'd0, "rst_stores");
    ld(MB + 32'hC, 3'b010, 32'h0, "rst_fstat");
    ld(MB + 32'h10, 3'b010, 32'h0, "rst_faddr");
    ld(32'h0, 3'b010, 32'h0000_CAFE, "rst_store_ignored");

    tick(); tick();
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
